// File: rtl/shift_reg_seq.sv
// Command sequencer for a WIDTH-bit universal shift register.
// Accepts one command at a time (valid/ready), drives the register's mode,
// parallel and serial inputs, and streams a loaded word out LSB first.
// All outputs except ser_out come straight from flops (Moore style).
module shift_reg_seq #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             cmd_fill,
   output logic [1:0]       sr_s,
   output logic [WIDTH-1:0] sr_in,
   output logic             sr_serial_in,
   input  logic [WIDTH-1:0] sr_q,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] MODE_UP   = 2'b00;  // toward MSB, serial into LSB
   localparam logic [1:0] MODE_DN   = 2'b01;  // toward LSB, serial into MSB
   localparam logic [1:0] MODE_LOAD = 2'b10;
   localparam logic [1:0] MODE_HOLD = 2'b11;

   localparam logic [CNT_W-1:0] SER_COUNT = CNT_W'(WIDTH);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       op_q;
   logic             cmd_ready_q;
   logic             busy_q;
   logic             done_q;
   logic             ser_valid_q;
   logic [1:0]       sr_s_q;
   logic [WIDTH-1:0] data_q;
   logic             fill_q;

   // Only the LSB of the register is tapped; the rest is observed for completeness.
   logic sr_q_unused;
   assign sr_q_unused = ^sr_q[WIDTH-1:1];

   // Sequencer state, counter, latched command and registered outputs.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         op_q        <= 2'b00;
         data_q      <= '0;
         fill_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ser_valid_q <= 1'b0;
         sr_s_q      <= MODE_HOLD;
      end else begin
         // Defaults describe a cycle in which the register holds.
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b1;
         done_q      <= 1'b0;
         ser_valid_q <= 1'b0;
         sr_s_q      <= MODE_HOLD;
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  op_q   <= cmd_op;
                  data_q <= cmd_data;
                  fill_q <= cmd_fill;
                  cnt_q  <= cmd_count;
                  if (cmd_op[1]) begin
                     state_q <= ST_LOAD;
                     sr_s_q  <= MODE_LOAD;
                  end else if (cmd_count != '0) begin
                     state_q <= ST_SHIFT;
                     sr_s_q  <= cmd_op[0] ? MODE_DN : MODE_UP;
                  end else begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end
               end else begin
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (op_q[0]) begin
                  // Load-then-serialize: shift the whole word out toward the LSB.
                  state_q     <= ST_SHIFT;
                  cnt_q       <= SER_COUNT;
                  sr_s_q      <= MODE_DN;
                  ser_valid_q <= 1'b1;
               end else begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
            ST_SHIFT: begin
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else begin
                  sr_s_q      <= (op_q == 2'b00) ? MODE_UP : MODE_DN;
                  ser_valid_q <= (op_q == 2'b11);
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               cmd_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign ser_valid    = ser_valid_q;
   assign sr_s         = sr_s_q;
   assign sr_in        = data_q;
   assign sr_serial_in = fill_q;
   assign ser_out      = sr_q[0];

endmodule

// File: tb/tb_shift_reg_seq.sv
// Bench for shift_reg_seq: a universal shift register sits behind the
// sequencer, a cycle-index model predicts every output, and directed plus
// random commands exercise it.
module tb_shift_reg_seq;
   localparam int W = 4;
   localparam int C = 3;

   logic         Clk = 1'b0;
   logic         Rst = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [1:0]   cmd_op = 2'b00;
   logic [W-1:0] cmd_data = '0;
   logic [C-1:0] cmd_count = '0;
   logic         cmd_fill = 1'b0;
   logic [1:0]   sr_s;
   logic [W-1:0] sr_in;
   logic         sr_serial_in;
   logic [W-1:0] sr_q;
   logic         ser_out;
   logic         ser_valid;
   logic         busy;
   logic         done;

   int total = 0;
   int bad = 0;
   logic check_en = 1'b0;

   shift_reg_seq #(.WIDTH(W), .CNT_W(C)) dut (
      .Clk(Clk), .Rst(Rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
      .cmd_fill(cmd_fill), .sr_s(sr_s), .sr_in(sr_in),
      .sr_serial_in(sr_serial_in), .sr_q(sr_q), .ser_out(ser_out),
      .ser_valid(ser_valid), .busy(busy), .done(done)
   );

   always #5 Clk = ~Clk;

   // The sequenced universal shift register (not reset; holds in mode 11).
   logic [W-1:0] reg_q = '0;
   assign sr_q = reg_q;
   always @(posedge Clk) begin
      case (sr_s)
         2'b00:   reg_q <= {reg_q[W-2:0], sr_serial_in};
         2'b01:   reg_q <= {sr_serial_in, reg_q[W-1:1]};
         2'b10:   reg_q <= sr_in;
         default: reg_q <= reg_q;
      endcase
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Register contents after a whole command, from plain arithmetic.
   function automatic logic [W-1:0] final_q(input logic [1:0] op, input logic [W-1:0] d,
                                            input int n, input logic f, input logic [W-1:0] q);
      int v;
      int r;
      int m;
      m = (1 << W) - 1;
      v = int'(q);
      case (op)
         2'b00:   r = (v << n) | (f ? ((1 << n) - 1) : 0);
         2'b01:   r = (v >> n) | (f ? (m & ~(m >> n)) : 0);
         2'b10:   r = int'(d);
         default: r = f ? m : 0;
      endcase
      r = r & m;
      return r[W-1:0];
   endfunction

   // Model: a command occupies cycles 1..len after its acceptance edge.
   logic         m_active;
   int           m_k;
   int           m_len;
   logic [1:0]   m_op;
   logic [W-1:0] m_data;
   logic         m_fill;
   logic [W-1:0] m_final;

   always @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         m_active <= 1'b0;
         m_k      <= 0;
         m_len    <= 0;
         m_op     <= 2'b00;
         m_data   <= '0;
         m_fill   <= 1'b0;
         m_final  <= '0;
      end else if (m_active) begin
         if (m_k >= m_len) m_active <= 1'b0;
         else m_k <= m_k + 1;
      end else if (cmd_valid) begin
         m_active <= 1'b1;
         m_k      <= 1;
         m_op     <= cmd_op;
         m_data   <= cmd_data;
         m_fill   <= cmd_fill;
         m_len    <= (cmd_op == 2'b10) ? 2 : (cmd_op == 2'b11) ? W + 2 : int'(cmd_count) + 1;
         m_final  <= final_q(cmd_op, cmd_data, int'(cmd_count), cmd_fill, sr_q);
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge Clk) begin : cmp
      logic e_done, e_load, e_shift, e_sv;
      logic [1:0] e_s;
      if (check_en) begin
         e_done  = m_active && (m_k == m_len);
         e_load  = m_active && m_op[1] && (m_k == 1);
         e_shift = m_active && !e_done && !e_load;
         e_sv    = e_shift && (m_op == 2'b11);
         e_s     = e_load ? 2'b10 : e_shift ? ((m_op == 2'b00) ? 2'b00 : 2'b01) : 2'b11;
         chk("cmd_ready", int'(cmd_ready), int'(!m_active));
         chk("busy", int'(busy), int'(m_active));
         chk("done", int'(done), int'(e_done));
         chk("ser_valid", int'(ser_valid), int'(e_sv));
         chk("sr_s", int'(sr_s), int'(e_s));
         chk("sr_in", int'(sr_in), int'(m_data));
         chk("sr_serial_in", int'(sr_serial_in), int'(m_fill));
         if (e_sv) chk("ser_out", int'(ser_out), int'(m_data[m_k - 2]));
         if (e_done) chk("final_q", int'(sr_q), int'(m_final));
      end
   end

   // Present a command and return #1 after the edge that accepts it.
   task automatic issue(input logic [1:0] op, input logic [W-1:0] d, input logic [C-1:0] n,
                        input logic f, input logic keep, output int waited);
      waited = 0;
      cmd_op = op; cmd_data = d; cmd_count = n; cmd_fill = f; cmd_valid = 1'b1;
      while (!cmd_ready && waited < 200) begin
         @(negedge Clk);
         waited++;
      end
      chk("accept_in_time", int'(waited < 200), 1);
      @(posedge Clk);
      #1;
      if (!keep) cmd_valid = 1'b0;
   endtask

   // Count cycles from acceptance until done, collecting serialized bits.
   task automatic wait_done(output int cycles, output logic [W-1:0] bits, output int nbits);
      cycles = 0; bits = '0; nbits = 0;
      do begin
         @(negedge Clk);
         cycles++;
         if (ser_valid && nbits < W) begin
            bits[nbits] = ser_out;
            nbits++;
         end
      end while (!done && cycles < 200);
      chk("done_seen", int'(done), 1);
   endtask

   initial begin
      int w, cyc, nb;
      logic [W-1:0] bits, hold;
      #1 Rst = 1'b1;
      repeat (3) @(negedge Clk);
      Rst = 1'b0;
      check_en = 1'b1;
      chk("rst_ready", int'(cmd_ready), 1);
      chk("rst_sr_s", int'(sr_s), 3);
      chk("rst_busy", int'(busy), 0);

      // Load then hold.
      issue(2'b10, 4'b1011, 3'd0, 1'b0, 1'b0, w);
      wait_done(cyc, bits, nb);
      chk("load_cycles", cyc, 2);
      chk("load_q", int'(sr_q), 11);
      repeat (10) @(negedge Clk);
      chk("load_hold_q", int'(sr_q), 11);

      // Shift toward MSB with fill 1 from 0001.
      issue(2'b10, 4'b0001, 3'd0, 1'b0, 1'b0, w);
      wait_done(cyc, bits, nb);
      issue(2'b00, 4'b0000, 3'd3, 1'b1, 1'b0, w);
      wait_done(cyc, bits, nb);
      chk("up_cycles", cyc, 4);
      chk("up_q", int'(sr_q), 15);
      @(negedge Clk);
      chk("up_busy_after", int'(busy), 0);

      // Zero count: done immediately, register untouched.
      issue(2'b01, 4'b0000, 3'd0, 1'b1, 1'b0, w);
      wait_done(cyc, bits, nb);
      chk("zero_cycles", cyc, 1);
      chk("zero_q", int'(sr_q), 15);

      // Serialize 0110 with fill 0.
      issue(2'b11, 4'b0110, 3'd0, 1'b0, 1'b0, w);
      wait_done(cyc, bits, nb);
      chk("ser_cycles", cyc, 6);
      chk("ser_nbits", nb, 4);
      chk("ser_bits", int'(bits), 6);
      chk("ser_q", int'(sr_q), 0);

      // Back-to-back with cmd_valid held: second accepted after LOAD, DONE, IDLE.
      issue(2'b10, 4'b1010, 3'd0, 1'b0, 1'b1, w);
      issue(2'b00, 4'b0000, 3'd2, 1'b0, 1'b0, w);
      chk("b2b_wait", w, 3);
      wait_done(cyc, bits, nb);
      chk("b2b_q", int'(sr_q), 8);

      // Reset in the middle of a 5-count shift.
      @(negedge Clk);
      issue(2'b00, 4'b0000, 3'd5, 1'b1, 1'b0, w);
      @(negedge Clk);
      @(negedge Clk);
      #2 Rst = 1'b1;
      #1;
      chk("mid_rst_sr_s", int'(sr_s), 3);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_ready", int'(cmd_ready), 1);
      chk("mid_rst_done", int'(done), 0);
      hold = sr_q;
      @(negedge Clk);
      #2 Rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         chk("post_rst_hold", int'(sr_q), int'(hold));
         chk("post_rst_done", int'(done), 0);
      end

      // Random commands with random idle gaps.
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge Clk);
         issue(2'($urandom_range(0, 3)), 4'($urandom), 3'($urandom), 1'($urandom), 1'b0, w);
         wait_done(cyc, bits, nb);
      end
      repeat (3) @(negedge Clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "time limit");
   end
endmodule
